// File: rtl/branch_predictor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_predictor : direct-mapped BTB + saturating-counter BHT, EX-stage
//                    mispredict detection and resolution statistics.
// Revision: 1.0
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int DATA_LEN = 32,
  parameter int ENTRIES  = 16,
  parameter int CNT_BITS = 2,
  parameter int STAT_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [DATA_LEN-1:0] if_pc,
  output logic                pred_taken,
  output logic [DATA_LEN-1:0] pred_target,
  input  logic                upd_valid,
  input  logic [DATA_LEN-1:0] upd_pc,
  input  logic                upd_is_br,
  input  logic                upd_taken,
  input  logic [DATA_LEN-1:0] upd_target,
  input  logic                upd_pred_taken,
  input  logic [DATA_LEN-1:0] upd_pred_target,
  output logic                mispredict,
  output logic [DATA_LEN-1:0] redirect_pc,
  output logic [STAT_LEN-1:0] stat_branches,
  output logic [STAT_LEN-1:0] stat_mispredicts
);

  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = DATA_LEN - IDX - 2;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(1) << (CNT_BITS - 1);

  logic [ENTRIES-1:0]               valid_q, valid_d;
  logic [ENTRIES-1:0][CNT_BITS-1:0] cnt_q, cnt_d;
  logic [TAG_W-1:0]                 tag_q [ENTRIES];
  logic [TAG_W-1:0]                 tag_d [ENTRIES];
  logic [DATA_LEN-1:0]              tgt_q [ENTRIES];
  logic [DATA_LEN-1:0]              tgt_d [ENTRIES];
  logic [STAT_LEN-1:0]              stat_br_q, stat_br_d;
  logic [STAT_LEN-1:0]              stat_mp_q, stat_mp_d;

  logic [IDX-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             br_event, upd_en;

  assign lk_idx = if_pc[IDX+1:2];
  assign lk_tag = if_pc[DATA_LEN-1:IDX+2];
  assign up_idx = upd_pc[IDX+1:2];
  assign up_tag = upd_pc[DATA_LEN-1:IDX+2];

  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign pred_taken  = lk_hit && cnt_q[lk_idx][CNT_BITS-1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : if_pc + DATA_LEN'(4);

  always_comb begin
    mispredict = 1'b0;
    if (reset && upd_valid) begin
      if (upd_is_br)
        mispredict = (upd_taken != upd_pred_taken) ||
                     (upd_taken && (upd_target != upd_pred_target));
      else
        mispredict = upd_pred_taken;
    end
  end

  assign redirect_pc = (upd_is_br && upd_taken) ? upd_target : upd_pc + DATA_LEN'(4);

  assign br_event = reset && upd_valid && upd_is_br;
  // flush wins over a same-cycle update; the stats below still see it
  assign upd_en   = reset && upd_valid && !flush;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (reset && flush) begin
      valid_d = '0;
    end else if (upd_en) begin
      if (upd_is_br) begin
        if (up_hit) begin
          if (upd_taken) begin
            if (cnt_q[up_idx] != CNT_MAX) cnt_d[up_idx] = cnt_q[up_idx] + CNT_BITS'(1);
            tgt_d[up_idx] = upd_target;
          end else if (cnt_q[up_idx] != '0) begin
            cnt_d[up_idx] = cnt_q[up_idx] - CNT_BITS'(1);
          end
        end else if (upd_taken) begin
          valid_d[up_idx] = 1'b1;
          tag_d[up_idx]   = up_tag;
          tgt_d[up_idx]   = upd_target;
          cnt_d[up_idx]   = CNT_WEAK;
        end
      end else if (up_hit) begin
        valid_d[up_idx] = 1'b0;
      end
    end
  end

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (br_event && (stat_br_q != '1))   stat_br_d = stat_br_q + STAT_LEN'(1);
    if (mispredict && (stat_mp_q != '1)) stat_mp_d = stat_mp_q + STAT_LEN'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      cnt_q     <= '0;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  // Tag/target storage carries no reset; writes are already gated by reset in upd_en
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_LEN, 32: PC/target width.
- ENTRIES, 16: BTB/BHT entry count, power of two, >=2.
- CNT_BITS, 2: saturating-counter width, >=1.
- STAT_LEN, 32: statistics counter width.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous clear of all entry valid bits.
- if_pc, in, DATA_LEN: fetch-stage lookup PC.
- pred_taken, out, 1: prediction for if_pc.
- pred_target, out, DATA_LEN: predicted next PC.
- upd_valid, in, 1: EX-stage resolution strobe.
- upd_pc, in, DATA_LEN: PC of the resolved instruction.
- upd_is_br, in, 1: the resolved instruction is a branch or JAL/JALR.
- upd_taken, in, 1: actual direction.
- upd_target, in, DATA_LEN: actual target.
- upd_pred_taken, in, 1: prediction carried down the pipe with the instruction.
- upd_pred_target, in, DATA_LEN: predicted target carried down the pipe.
- mispredict, out, 1: flush request.
- redirect_pc, out, DATA_LEN: correct next PC.
- stat_branches, out, STAT_LEN: resolved control transfers.
- stat_mispredicts, out, STAT_LEN: mispredictions.

Function
REQ-003 Address fields:
- IDX = log2(ENTRIES).
- Index = pc[IDX+1:2].
- Tag = pc[DATA_LEN-1:IDX+2].
- pc[1:0] is ignored.
REQ-004 Each entry SHALL hold valid, tag, target (DATA_LEN) and a CNT_BITS saturating counter.
REQ-005 Lookup SHALL be combinational:
- hit = valid && tag match at the if_pc index.
- pred_taken = hit && counter MSB.
- pred_target = stored target when pred_taken, else if_pc+4 (mod 2^DATA_LEN).
REQ-006 mispredict SHALL be combinational and SHALL assert when upd_valid and any of the following holds:
- upd_is_br && upd_taken != upd_pred_taken;
- upd_is_br && upd_taken && upd_target != upd_pred_target;
- !upd_is_br && upd_pred_taken.
REQ-007 redirect_pc SHALL be upd_target when upd_is_br && upd_taken, else upd_pc+4; its value is don't-care when mispredict=0.
REQ-008 Table writes SHALL occur only at the rising clk edge. A lookup in the same cycle as an update to the same index SHALL see the pre-update contents.
REQ-009 Update on upd_valid && upd_is_br with a hit at the upd_pc index:
- counter +1 if taken, saturating at 2^CNT_BITS-1;
- counter -1 if not taken, saturating at 0;
- target overwritten with upd_target if taken.
REQ-010 Update on upd_valid && upd_is_br with a miss:
- if taken, allocate (replacing any occupant): valid=1, tag, target=upd_target, counter=2^(CNT_BITS-1) (weakly taken);
- if not taken, no allocation.
REQ-011 Update on upd_valid && !upd_is_br with a hit SHALL clear that entry's valid bit (alias removal); otherwise no change.
REQ-012 flush=1 SHALL clear all valid bits at the edge and SHALL take priority over a same-cycle update, which is discarded. Statistics SHALL still count that update.
REQ-013 Statistics counters:
- stat_branches SHALL increment on upd_valid && upd_is_br.
- stat_mispredicts SHALL increment on mispredict.
- Both SHALL saturate at all-ones (no wrap).
- Both SHALL be registered, with the increment visible the cycle after the event.
REQ-014 While reset=0, mispredict SHALL be forced to 0 and no table or statistics state SHALL change.

Reset
REQ-015 reset=0 SHALL asynchronously clear every valid bit, every counter and both statistics registers, without waiting for a clk edge.
REQ-016 During and immediately after reset: pred_taken=0, pred_target=if_pc+4, mispredict=0, stat_*=0.
REQ-017 Target and tag storage need no reset value.
REQ-018 Reset asserted mid-update SHALL abandon that update.

Verification (ENTRIES=16, CNT_BITS=2)
REQ-019 Post-reset lookup: reset released, if_pc=0x100 -> pred_taken=0, pred_target=0x104.
REQ-020 Allocate on taken miss:
- Stimulus: upd pc=0x100, is_br=1, taken=1, target=0x80, pred_taken=0.
- Same cycle: mispredict=1, redirect_pc=0x80.
- Next cycle: if_pc=0x100 gives pred_taken=1, pred_target=0x80; stat_branches=1, stat_mispredicts=1.
REQ-021 Saturation and hysteresis:
- Three more taken updates -> counter stays 3.
- Then two not-taken updates (pred_taken=1 supplied) -> counter 3->2->1.
- pred_taken after the first not-taken = 1; after the second = 0.
- The first not-taken asserts mispredict with redirect_pc=0x104.
REQ-022 Alias and flush:
- Entry for 0x100 present; if_pc=0x140 (same index 0, different tag) -> pred_taken=0.
- upd pc=0x100, is_br=0, pred_taken=1 -> mispredict=1, redirect_pc=0x104, entry invalidated.
- Separately, flush=1 together with a taken update -> no entry allocated; stat_branches still increments.
REQ-023 Async reset mid-run: drive reset=0 between clk edges after populated state -> pred_taken=0 and stat_*=0 before the next edge; mispredict=0 despite upd_valid=1.
